combo_decoder: RTL and testbench



---
 rtl/combo_decoder_pkg.sv | 17 +
 rtl/combo_window_timer.sv | 23 ++
 rtl/combo_decoder.sv | 76 +++++++
 tb/tb_combo_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/combo_decoder_pkg.sv
// Shared move codes and FSM state encoding for the special-move decoder.
package combo_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S_D  = 2'd1,
    S_DF = 2'd2,
    S_DB = 2'd3
  } state_t;

  localparam logic [2:0] MV_NONE      = 3'd0;
  localparam logic [2:0] MV_PUNCH     = 3'd1;
  localparam logic [2:0] MV_KICK      = 3'd2;
  localparam logic [2:0] MV_FIREBALL  = 3'd3;
  localparam logic [2:0] MV_SPIN_KICK = 3'd4;

endpackage

// File: rtl/combo_window_timer.sv
// Inter-step window counter; timeout flags the last allowed idle cycle of a step.
module combo_window_timer #(
  parameter int WIN_CYCLES = 25000000,
  parameter int CNT_W      = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign timeout = enable && (cnt == CNT_W'(WIN_CYCLES - 1));

endmodule

// File: rtl/combo_decoder.sv
// Per-player move decoder: plain attacks plus down-fwd-punch / down-back-kick specials.
module combo_decoder
  import combo_decoder_pkg::*;
#(
  parameter int WIN_CYCLES = 25000000,
  parameter int CNT_W      = 25
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       UP_P,
  input  logic       DOWN_P,
  input  logic       LEFT_P,
  input  logic       RIGHT_P,
  input  logic       PUNCH_P,
  input  logic       KICK_P,
  input  logic       FACING_RIGHT,
  output logic       MOVE_VALID,
  output logic [2:0] MOVE_CODE,
  output logic       SEQ_ACTIVE
);

  state_t state;
  logic   fwd, back, attack, any_in, timeout;

  // Mirror left/right into forward/back for the current facing.
  assign fwd    = FACING_RIGHT ? RIGHT_P : LEFT_P;
  assign back   = FACING_RIGHT ? LEFT_P  : RIGHT_P;
  assign attack = PUNCH_P | KICK_P;
  assign any_in = attack | UP_P | DOWN_P | fwd | back;

  // Any input in a sequence state causes a (re-)entry, so it restarts the window.
  combo_window_timer #(
    .WIN_CYCLES(WIN_CYCLES),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk    (CLK),
    .rst    (RESET),
    .clear  ((state == IDLE) || any_in || timeout),
    .enable (state != IDLE),
    .timeout(timeout)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      MOVE_VALID <= 1'b0;
      MOVE_CODE  <= MV_NONE;
      SEQ_ACTIVE <= 1'b0;
    end else begin
      MOVE_VALID <= 1'b0;
      if (attack) begin
        MOVE_VALID <= 1'b1;
        state      <= IDLE;
        SEQ_ACTIVE <= 1'b0;
        case (state)
          S_DF:    MOVE_CODE <= PUNCH_P ? MV_FIREBALL : MV_KICK;
          S_DB:    MOVE_CODE <= KICK_P  ? MV_SPIN_KICK : MV_PUNCH;
          default: MOVE_CODE <= PUNCH_P ? MV_PUNCH : MV_KICK;
        endcase
      end else if (DOWN_P) begin
        state      <= S_D;
        SEQ_ACTIVE <= 1'b1;
      end else if (state == S_D && fwd) begin
        state      <= S_DF;
        SEQ_ACTIVE <= 1'b1;
      end else if (state == S_D && back) begin
        state      <= S_DB;
        SEQ_ACTIVE <= 1'b1;
      end else if (state != IDLE && (UP_P || fwd || back || timeout)) begin
        state      <= IDLE;
        SEQ_ACTIVE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_combo_decoder.sv
// Directed + random bench for combo_decoder against a step-history reference model.
module tb_combo_decoder;

  localparam int WIN = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       UP_P = 0, DOWN_P = 0, LEFT_P = 0, RIGHT_P = 0, PUNCH_P = 0, KICK_P = 0;
  logic       FACING_RIGHT = 1'b1;
  logic       MOVE_VALID;
  logic [2:0] MOVE_CODE;
  logic       SEQ_ACTIVE;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: the accepted step history as text, plus the cycle of the last step.
  string      seq = "";
  int         last_t = 0;
  logic       exp_valid = 0;
  logic [2:0] exp_code = 0;
  logic       exp_active = 0;

  combo_decoder #(.WIN_CYCLES(WIN), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .UP_P(UP_P), .DOWN_P(DOWN_P), .LEFT_P(LEFT_P),
    .RIGHT_P(RIGHT_P), .PUNCH_P(PUNCH_P), .KICK_P(KICK_P), .FACING_RIGHT(FACING_RIGHT),
    .MOVE_VALID(MOVE_VALID), .MOVE_CODE(MOVE_CODE), .SEQ_ACTIVE(SEQ_ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model(input logic u, d, l, r, p, k, f);
    logic fw, bk;
    fw = f ? r : l;
    bk = f ? l : r;
    exp_valid = 1'b0;
    if (seq != "" && cyc - last_t > WIN) seq = "";
    if (p || k) begin
      exp_valid = 1'b1;
      if (seq == "DF" && p)      exp_code = 3'd3;
      else if (seq == "DB" && k) exp_code = 3'd4;
      else                       exp_code = p ? 3'd1 : 3'd2;
      seq = "";
    end else if (d) begin
      seq = "D"; last_t = cyc;
    end else if (seq == "D" && fw) begin
      seq = "DF"; last_t = cyc;
    end else if (seq == "D" && bk) begin
      seq = "DB"; last_t = cyc;
    end else if (seq != "" && (u || fw || bk)) begin
      seq = "";
    end
    exp_active = (seq != "") && (cyc - last_t < WIN);
  endtask

  task automatic step(input logic u, d, l, r, p, k, f);
    UP_P = u; DOWN_P = d; LEFT_P = l; RIGHT_P = r; PUNCH_P = p; KICK_P = k;
    FACING_RIGHT = f;
    @(posedge CLK);
    cyc++;
    model(u, d, l, r, p, k, f);
    #1;
    chk("move_valid", {2'b0, MOVE_VALID}, {2'b0, exp_valid});
    chk("move_code", MOVE_CODE, exp_code);
    chk("seq_active", {2'b0, SEQ_ACTIVE}, {2'b0, exp_active});
    UP_P = 0; DOWN_P = 0; LEFT_P = 0; RIGHT_P = 0; PUNCH_P = 0; KICK_P = 0;
  endtask

  task automatic idle(input int n, input logic f);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, f);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {2'b0, MOVE_VALID}, 3'd0);
    chk({tag, "_code"}, MOVE_CODE, 3'd0);
    chk({tag, "_active"}, {2'b0, SEQ_ACTIVE}, 3'd0);
  endtask

  initial begin
    #1 check_zero("reset");
    @(posedge CLK); cyc++;
    @(posedge CLK); cyc++;
    #2 RESET = 1'b0;

    // Plain punch, then code held
    idle(4, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    idle(3, 1);
    // Fireball facing right, then facing left
    step(0, 1, 0, 0, 0, 0, 1); idle(2, 1);
    step(0, 0, 0, 1, 0, 0, 1); idle(2, 1);
    step(0, 0, 0, 0, 1, 0, 1); idle(2, 1);
    step(0, 1, 0, 0, 0, 0, 0); idle(2, 0);
    step(0, 0, 1, 0, 0, 0, 0); idle(2, 0);
    step(0, 0, 0, 0, 1, 0, 0); idle(2, 1);
    // Spin kick, and spin kick with punch+kick together
    step(0, 1, 0, 0, 0, 0, 1); step(0, 0, 1, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 1); step(0, 0, 1, 0, 0, 0, 1); step(0, 0, 0, 0, 1, 1, 1);
    // Kick from down-fwd, left+right together meaning fwd
    step(0, 1, 0, 0, 0, 0, 1); step(0, 0, 1, 1, 0, 0, 1); step(0, 0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1); step(0, 0, 0, 1, 0, 0, 1); step(0, 0, 0, 0, 0, 1, 1);
    // Timeout: step one cycle past the window is ignored
    step(0, 1, 0, 0, 0, 0, 1); idle(WIN, 1);
    step(0, 0, 0, 1, 0, 0, 1); step(0, 0, 0, 0, 1, 0, 1);
    // Boundary: step on the last window cycle is accepted
    step(0, 1, 0, 0, 0, 0, 1); idle(WIN - 1, 1);
    step(0, 0, 0, 1, 0, 0, 1); step(0, 0, 0, 0, 1, 0, 1);
    // Interrupt by up, and restart by down
    step(0, 1, 0, 0, 0, 0, 1); step(0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1); step(0, 0, 0, 1, 0, 0, 1); step(0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1); step(0, 0, 0, 0, 1, 0, 1);
    // Reset mid-sequence
    step(0, 1, 0, 0, 0, 0, 1); step(0, 0, 0, 1, 0, 0, 1);
    RESET = 1'b1;
    #1 check_zero("rst_mid");
    @(posedge CLK); cyc++;
    #1 check_zero("rst_hold");
    RESET = 1'b0;
    seq = ""; exp_code = 3'd0; exp_valid = 1'b0; exp_active = 1'b0;
    idle(3, 1);
    step(0, 0, 0, 0, 1, 0, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic f;
      int   sel;
      f   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 15));
      case (sel)
        0:       idle(int'($urandom_range(6, 10)), f);
        1, 2, 3, 4, 5: step(0, 0, 0, 0, 0, 0, f);
        6:       step(1, 0, 0, 0, 0, 0, f);
        7, 8:    step(0, 1, 0, 0, 0, 0, f);
        9:       step(0, 0, 1, 0, 0, 0, f);
        10:      step(0, 0, 0, 1, 0, 0, f);
        11:      step(0, 0, 1, 1, 0, 0, f);
        12:      step(0, 0, 0, 0, 1, 0, f);
        13:      step(0, 0, 0, 0, 0, 1, f);
        14:      step(0, 0, 0, 0, 1, 1, f);
        default: step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1, 1'($urandom_range(0, 1)), f);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
